mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter. It acts as the responder on the CPU data-memory port,
//  alongside data_mem, and decodes a small register window at BASE_ADDR.
//  CPU stores enqueue bytes into a FIFO; an FSM serialises them as 8N1 frames, LSB first, on tx.
//  CPU loads return status, so software can poll before each store.
// PARAMETERS
//  BASE_ADDR     32'h0000_0100  byte address of the register window (16-byte aligned)
//  FIFO_DEPTH    8              TX FIFO entries; power of 2, at least 2
//  CLKS_PER_BIT  16             reset value of the DIV register
//  DIV_WIDTH     16             width of the DIV register
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, synchronous, active-high
//  write_en    in   1   store strobe, sampled on posedge clk
//  write_addr  in   32  store byte address
//  write_data  in   32  store data
//  read_addr   in   32  load byte address
//  read_data   out  32  load data, combinational from read_addr and current state
//  tx          out  1   serial output, idle high
//  busy        out  1   1 when FSM is not in IDLE or FIFO is not empty
// BEHAVIOUR
//  Register map (offsets from BASE_ADDR; addr[1:0] ignored):
//   0x0 TXDATA  W: push write_data[7:0] into FIFO.  R: 0.
//   0x4 STATUS  R: [0] busy, [1] full, [2] empty, [3] ovf (sticky), [15:8] count.
//               W: any write clears ovf.
//   0x8 DIV     R/W: [DIV_WIDTH-1:0] clocks per bit. A value of 0 behaves as 1.
//   0xC and out-of-window addresses: reads return 0; writes are ignored.
//  Reset: tx=1, busy=0, FIFO empty, count=0, ovf=0, DIV=CLKS_PER_BIT, FSM=IDLE.
//   read_data reflects reset state immediately (STATUS reads 32'h4).
//  FIFO: registered; a push is visible in count on the cycle after write_en.
//   Push when full and no pop in the same cycle: byte dropped, ovf<=1, count unchanged.
//   Push and pop in the same cycle: both take effect, count unchanged (also when full).
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx=1. If FIFO is not empty: pop head into shift reg, latch DIV into div_q,
//         bit_cnt<=0, go to START.
//   START: tx=0 for div_q cycles.
//   DATA: tx=shift[0] for div_q cycles per bit; shift right after each bit; after 8 bits go on.
//   STOP: tx=1 for div_q cycles, then IDLE.
//   Baud counter counts div_q-1 down to 0; the state or bit advances on 0.
//  Latency: store to TXDATA at cycle N with FIFO empty and FSM idle:
//   pop at N+1, tx falls at N+2.
//  Back-to-back frames are separated by exactly one IDLE cycle (tx=1).
//  DIV writes mid-frame do not affect the current frame (div_q is latched per frame).
//  A STATUS read in the same cycle as a push returns the pre-push values.
//  Reset mid-frame: tx returns to 1 the next cycle, the FIFO is flushed, the frame is aborted.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA;
//   tx = XOR of the 8 data bits (even parity) for div_q cycles; frame = 11*div_q cycles.
//  UART_TX_PARITY_EN undefined: no PARITY state; 8N1 frame = 10*div_q cycles.
// TESTING
//  1. Reset, load BASE+4 -> read_data=32'h4, tx=1, busy=0.
//  2. DIV=4, store 8'hA5 to BASE+0 at cycle N -> tx falls at N+2.
//     Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high for 4 cycles, then busy=0.
//  3. Nine stores with DIV=100 and no drain (depth 8) -> count=8, full=1.
//     The first byte has already popped, so the ninth push is accepted.
//     A tenth push sets ovf=1. Store to BASE+4 -> ovf=0.
//  4. Stores 8'h01 then 8'h02 -> two frames, tx=1 for exactly 1 cycle between them.
//  5. DIV write to 2 during a DIV=8 frame -> current frame stays at 8 clk/bit; next frame uses 2.
//  6. Assert reset mid-DATA -> tx=1 next cycle, STATUS=32'h4; with UART_TX_PARITY_EN, 8'h07 sends parity 1.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIV register window feeding a byte FIFO
// and an 8N1 serialiser. Define UART_TX_PARITY_EN to append an even-parity bit to each frame.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DIV_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic [31:0] read_addr,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   ovf_q;
  logic [DIV_WIDTH-1:0]   div_reg_q, div_eff, div_q, baud_q;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   full, empty, pop, push, push_ok, wr_hit, baud_zero;
  logic                   unused_bits;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  assign wr_hit    = write_en && (write_addr[31:4] == BASE_ADDR[31:4]);
  assign push      = wr_hit && (write_addr[3:2] == 2'd0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);
  assign busy      = (state_q != S_IDLE) || !empty;
  assign baud_zero = (baud_q == '0);
  assign div_eff   = (div_reg_q == '0) ? DIV_WIDTH'(1) : div_reg_q;
  assign unused_bits = ^{write_data[31:8], write_addr[1:0], read_addr[1:0]};

  always_comb begin
    read_data = '0;
    if (read_addr[31:4] == BASE_ADDR[31:4]) begin
      case (read_addr[3:2])
        2'd1: begin
          read_data[0]       = busy;
          read_data[1]       = full;
          read_data[2]       = empty;
          read_data[3]       = ovf_q;
          read_data[8 +: CW] = count_q;
        end
        2'd2:    read_data[DIV_WIDTH-1:0] = div_reg_q;
        default: read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_reg_q <= DIV_WIDTH'(CLKS_PER_BIT);
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop) count_q <= count_q - CW'(1);
      if (push && !push_ok)                        ovf_q <= 1'b1;
      else if (wr_hit && write_addr[3:2] == 2'd1)  ovf_q <= 1'b0;
      if (wr_hit && write_addr[3:2] == 2'd2) div_reg_q <= write_data[DIV_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_zero) state_d = S_DATA;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (baud_zero && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx = par_q;
        if (baud_zero) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_zero) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // div_q is captured at pop so DIV writes only affect the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= DIV_WIDTH'(1);
      baud_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (pop) begin
        shift_q   <= fifo_mem[rd_ptr_q];
        div_q     <= div_eff;
        baud_q    <= div_eff - DIV_WIDTH'(1);
        bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
        par_q     <= ^fifo_mem[rd_ptr_q];
`endif
      end else if (state_q != S_IDLE) begin
        if (baud_zero) begin
          baud_q <= div_q - DIV_WIDTH'(1);
          if (state_q == S_DATA) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end else begin
          baud_q <= baud_q - DIV_WIDTH'(1);
        end
      end
    end
  end

endmodule
